// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, MRET and machine interrupts, then strobes
// the CSR trap-entry / mode-change inputs, flushes the pipe and redirects fetch.
module trap_ctrl #(
   parameter int DRAIN_CYCLES    = 2,
   parameter int INT_SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mmu_wait_i,
   input  logic        exc_en_i,
   input  logic [31:0] exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic        mret_en_i,
   input  logic [31:0] mepc_i,
   input  logic        int_soft_i,
   input  logic        int_timer_i,
   input  logic        int_ext_i,
   input  logic        int_pc_valid_i,
   input  logic [31:0] int_pc_i,
   input  logic        int_allow_i,
   input  logic [1:0]  trap_vec_mode_i,
   input  logic [31:0] trap_vec_base_i,
   output logic        trap_en_o,
   output logic [31:0] trap_code_o,
   output logic [31:0] trap_pc_o,
   output logic        chmode_do_o,
   output logic [1:0]  chmode_to_o,
   output logic        flush_o,
   output logic        jmp_do_o,
   output logic [31:0] jmp_pc_o,
   output logic        busy_o
);

   // state    | meaning
   // IDLE     | waiting for a request (accepted only when mmu_wait_i is low)
   // COMMIT   | trap-entry or mode-change strobe, flush
   // REDIRECT | fetch redirect strobe, flush
   // DRAIN    | flush held for DRAIN_CYCLES cycles
   typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, DRAIN} state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   state_t state_q;
   logic [INT_SYNC_STAGES-1:0][2:0] sync_q;
   logic [3:0]  drain_cnt_q;
   logic [31:0] target_q;
   logic        trap_en_q, chmode_do_q, flush_q, jmp_do_q;
   logic [31:0] trap_code_q, trap_pc_q, jmp_pc_q;

   logic [2:0]  pend;
   logic [3:0]  cause_d;
   logic        accept_d, is_mret_d;
   logic [31:0] code_d, pc_d, target_d;

   // sync lanes are {ext, soft, timer}
   always_comb begin
      pend      = sync_q[INT_SYNC_STAGES-1] & {3{int_allow_i & int_pc_valid_i}};
      cause_d   = pend[2] ? 4'd11 : (pend[1] ? 4'd3 : 4'd7);
      accept_d  = (state_q == IDLE) && !mmu_wait_i && (exc_en_i || mret_en_i || (|pend));
      is_mret_d = !exc_en_i && mret_en_i;
      code_d    = exc_en_i ? exc_code_i : {1'b1, 27'b0, cause_d};
      pc_d      = exc_en_i ? exc_pc_i : int_pc_i;
      if (exc_en_i)
         target_d = trap_vec_base_i;
      else if (mret_en_i)
         target_d = mepc_i;
      else if (trap_vec_mode_i == 2'b01)
         target_d = trap_vec_base_i + {26'b0, cause_d, 2'b00};
      else
         target_d = trap_vec_base_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sync_q      <= '0;
         drain_cnt_q <= '0;
         target_q    <= '0;
         trap_en_q   <= 1'b0;
         chmode_do_q <= 1'b0;
         flush_q     <= 1'b0;
         jmp_do_q    <= 1'b0;
         trap_code_q <= '0;
         trap_pc_q   <= '0;
         jmp_pc_q    <= '0;
      end else begin
         sync_q[0] <= {int_ext_i, int_soft_i, int_timer_i};
         for (int i = 1; i < INT_SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];

         trap_en_q   <= 1'b0;
         chmode_do_q <= 1'b0;
         jmp_do_q    <= 1'b0;
         jmp_pc_q    <= '0;

         case (state_q)
            IDLE: begin
               flush_q <= 1'b0;
               if (accept_d) begin
                  state_q     <= COMMIT;
                  flush_q     <= 1'b1;
                  trap_en_q   <= !is_mret_d;
                  chmode_do_q <= is_mret_d;
                  target_q    <= target_d;
                  // MRET writes neither mcause nor mepc, so the last trap fields stay
                  if (!is_mret_d) begin
                     trap_code_q <= code_d;
                     trap_pc_q   <= pc_d;
                  end
               end
            end
            COMMIT: begin
               state_q  <= REDIRECT;
               jmp_do_q <= 1'b1;
               jmp_pc_q <= target_q;
               flush_q  <= 1'b1;
            end
            REDIRECT: begin
               if (DRAIN_CYCLES == 0) begin
                  state_q <= IDLE;
                  flush_q <= 1'b0;
               end else begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= DRAIN_LOAD;
                  flush_q     <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt_q == 4'd0) begin
                  state_q <= IDLE;
                  flush_q <= 1'b0;
               end else begin
                  drain_cnt_q <= drain_cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign trap_en_o   = trap_en_q;
   assign trap_code_o = trap_code_q;
   assign trap_pc_o   = trap_pc_q;
   assign chmode_do_o = chmode_do_q;
   assign chmode_to_o = 2'b11;
   assign flush_o     = flush_q;
   assign jmp_do_o    = jmp_do_q;
   assign jmp_pc_o    = jmp_pc_q;
   assign busy_o      = (state_q != IDLE);

endmodule
